// File: rtl/ahb_cache_bridge_if.sv
// AHB-Lite slave port, cache-controller request port and perf counters of ahb_cache_bridge.
// The bridge connects through 'slave'; the bus fabric plus cache side uses 'master'.
interface ahb_cache_bridge_if #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
);
   // AHB-Lite side
   logic              ahbls_hready;
   logic              ahbls_hready_resp;
   logic              ahbls_hresp;
   logic [W_ADDR-1:0] ahbls_haddr;
   logic              ahbls_hwrite;
   logic [1:0]        ahbls_htrans;
   logic [2:0]        ahbls_hsize;
   logic              ahbls_hsel;
   logic [W_DATA-1:0] ahbls_hwdata;
   logic [W_DATA-1:0] ahbls_hrdata;

   // cache_ctrl side
   logic              c_rd_en;
   logic              c_wr_en;
   logic [W_ADDR-1:0] c_addr;
   logic [W_DATA-1:0] c_wdata;
   logic [3:0]        c_mask;
   logic [W_DATA-1:0] c_rdata;
   logic              c_busy;

   logic [31:0]       perf_rd_hit;
   logic [31:0]       perf_rd_miss;

   modport slave (
      input  ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize,
             ahbls_hsel, ahbls_hwdata, c_rdata, c_busy,
      output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
             c_rd_en, c_wr_en, c_addr, c_wdata, c_mask, perf_rd_hit, perf_rd_miss
   );

   modport master (
      output ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize,
             ahbls_hsel, ahbls_hwdata, c_rdata, c_busy,
      input  ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
             c_rd_en, c_wr_en, c_addr, c_wdata, c_mask, perf_rd_hit, perf_rd_miss
   );
endinterface

// File: rtl/ahb_cache_bridge.sv
// AHB-Lite slave that turns each bus transfer into one rd_en/wr_en pulse to cache_ctrl,
// holds address/data/mask until the cache drops busy, and errors misaligned transfers.
module ahb_cache_bridge #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
) (
   input logic               clk,
   input logic               rst,
   ahb_cache_bridge_if.slave bus
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_CHK  = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_ERR1 = 3'd4;
   localparam logic [2:0] S_ERR2 = 3'd5;

   logic [2:0]        state;
   logic [2:0]        state_nx;
   logic [W_ADDR-1:0] addr_q;
   logic              hwrite_q;
   logic [3:0]        mask_q;
   logic [W_DATA-1:0] wdata_q;
   logic [W_DATA-1:0] rdata_q;
   logic [31:0]       hit_q;
   logic [31:0]       miss_q;

   logic [3:0] mask_nx;
   logic       legal;
   logic       chk_hit;
   logic       done;
   logic       open;
   logic       accept;
   logic       unused_htrans;

   assign unused_htrans = bus.ahbls_htrans[0];

   // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      mask_nx = 4'b0000;
      legal   = 1'b0;
      case (bus.ahbls_hsize)
         3'd0: begin
            mask_nx = 4'b0001 << bus.ahbls_haddr[1:0];
            legal   = 1'b1;
         end
         3'd1: begin
            mask_nx = bus.ahbls_haddr[1] ? 4'b1100 : 4'b0011;
            legal   = ~bus.ahbls_haddr[0];
         end
         3'd2: begin
            mask_nx = 4'b1111;
            legal   = (bus.ahbls_haddr[1:0] == 2'b00);
         end
         default: ;
      endcase
   end

   // A read hit completes in CHK; everything else finishes in WAIT on the first non-busy cycle.
   assign chk_hit = (state == S_CHK) && !hwrite_q && !bus.c_busy;
   assign done    = chk_hit || ((state == S_WAIT) && !bus.c_busy);
   assign open    = (state == S_IDLE) || (state == S_ERR2) || done;
   assign accept  = bus.ahbls_hsel && bus.ahbls_hready && bus.ahbls_htrans[1] && open;

   always_comb begin
      state_nx = S_IDLE;
      case (state)
         S_REQ:   state_nx = S_CHK;
         S_CHK:   state_nx = chk_hit ? S_IDLE : S_WAIT;
         S_WAIT:  state_nx = bus.c_busy ? S_WAIT : S_IDLE;
         S_ERR1:  state_nx = S_ERR2;
         default: state_nx = S_IDLE;
      endcase
      if (accept) state_nx = legal ? S_REQ : S_ERR1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         addr_q   <= '0;
         hwrite_q <= 1'b0;
         mask_q   <= 4'b0000;
         wdata_q  <= '0;
         rdata_q  <= '0;
         hit_q    <= '0;
         miss_q   <= '0;
      end else begin
         state <= state_nx;
         if (accept && legal) begin
            addr_q   <= {bus.ahbls_haddr[W_ADDR-1:2], 2'b00};
            hwrite_q <= bus.ahbls_hwrite;
            mask_q   <= mask_nx;
         end
         if (state == S_REQ) begin
            wdata_q <= bus.ahbls_hwdata;
            rdata_q <= bus.c_rdata;
         end
         if ((state == S_CHK) && !hwrite_q) begin
            if (bus.c_busy) miss_q <= miss_q + 32'd1;
            else            hit_q  <= hit_q + 32'd1;
         end
      end
   end

   assign bus.ahbls_hready_resp = open;
   assign bus.ahbls_hresp       = (state == S_ERR1) || (state == S_ERR2);
   // On a miss the cache holds the refill word on o_data during the completing cycle.
   assign bus.ahbls_hrdata      = (state == S_WAIT) ? bus.c_rdata : rdata_q;

   assign bus.c_rd_en      = (state == S_REQ) && !hwrite_q;
   assign bus.c_wr_en      = (state == S_REQ) && hwrite_q;
   assign bus.c_addr       = addr_q;
   assign bus.c_wdata      = (state == S_REQ) ? bus.ahbls_hwdata : wdata_q;
   assign bus.c_mask       = mask_q;
   assign bus.perf_rd_hit  = hit_q;
   assign bus.perf_rd_miss = miss_q;
endmodule

// File: tb/tb_ahb_cache_bridge.sv
// Bench for ahb_cache_bridge: AHB master driver, behavioural cache/DRAM model and a
// byte-level reference memory feeding response and request scoreboards.
module tb_ahb_cache_bridge;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ahb_cache_bridge_if #(.W_ADDR(32), .W_DATA(32)) bus ();
   assign bus.ahbls_hready = bus.ahbls_hready_resp;

   ahb_cache_bridge #(.W_ADDR(32), .W_DATA(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct { bit err; bit wr; logic [31:0] rdata; } resp_t;
   typedef struct { bit wr; logic [31:0] addr; logic [3:0] mask; logic [31:0] wdata; } req_t;

   resp_t resp_q[$];
   req_t  req_q[$];

   logic [7:0]  ref_bytes [int unsigned];
   logic [31:0] mem       [int unsigned];
   bit          cached    [int unsigned];

   int          checks = 0;
   int          errors = 0;
   int          pulses = 0;
   int          exp_pulses = 0;
   int          exp_hit = 0;
   int          exp_miss = 0;
   int          force_lat = 0;
   int unsigned cyc = 0;
   int unsigned last_cpl_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] dram(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : dram(a);
   endfunction

   function automatic logic [7:0] ref_byte(input logic [31:0] a);
      logic [31:0] w;
      if (ref_bytes.exists(a)) return ref_bytes[a];
      w = dram({a[31:2], 2'b00});
      return w[8*a[1:0] +: 8];
   endfunction

   // Bus activity the bridge must ignore: deselected, or IDLE/BUSY transfer types.
   task automatic noise();
      case ($urandom_range(0, 2))
         0:       begin bus.ahbls_hsel = 1'b0; bus.ahbls_htrans = 2'b10; end
         1:       begin bus.ahbls_hsel = 1'b1; bus.ahbls_htrans = 2'b00; end
         default: begin bus.ahbls_hsel = 1'b1; bus.ahbls_htrans = 2'b01; end
      endcase
      bus.ahbls_haddr  = $urandom;
      bus.ahbls_hwrite = 1'($urandom_range(0, 1));
      bus.ahbls_hsize  = 3'($urandom_range(0, 3));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         noise();
         @(posedge clk); #1;
      end
   endtask

   // Presents one address phase, waits for acceptance, then drives its data phase.
   task automatic issue(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata);
      bit          ok;
      bit          legal;
      int          n;
      int          nbytes;
      logic [31:0] base;
      resp_t       rs;
      req_t        rq;
      bus.ahbls_hsel   = 1'b1;
      bus.ahbls_htrans = 2'b10;
      bus.ahbls_haddr  = addr;
      bus.ahbls_hwrite = wr;
      bus.ahbls_hsize  = size;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 300) begin
         @(negedge clk);
         ok = bus.ahbls_hready;
         @(posedge clk); #1;
         n++;
      end
      check("accept", {31'd0, ok}, 32'd1);
      bus.ahbls_hwdata = wdata;
      noise();

      legal    = (size <= 3'd2) && ((addr % (32'd1 << size)) == 0);
      base     = {addr[31:2], 2'b00};
      rs.err   = !legal;
      rs.wr    = wr;
      rs.rdata = '0;
      if (legal) begin
         nbytes   = 1 << size;
         rq.wr    = wr;
         rq.addr  = base;
         rq.wdata = wdata;
         rq.mask  = 4'b0000;
         for (int b = 0; b < nbytes; b++) rq.mask[int'(addr[1:0]) + b] = 1'b1;
         if (wr) begin
            for (int b = 0; b < nbytes; b++)
               ref_bytes[addr + b] = wdata[8*((int'(addr[1:0]) + b) % 4) +: 8];
         end else begin
            rs.rdata = {ref_byte(base + 3), ref_byte(base + 2), ref_byte(base + 1), ref_byte(base)};
         end
         req_q.push_back(rq);
         exp_pulses++;
      end
      resp_q.push_back(rs);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (resp_q.size() != 0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain", resp_q.size(), 32'd0);
   endtask

   task automatic count_to_ready(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.ahbls_hready_resp && n < 200);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_hready_resp"}, {31'd0, bus.ahbls_hready_resp}, 32'd1);
      check({tag, "_hresp"},       {31'd0, bus.ahbls_hresp}, 32'd0);
      check({tag, "_hrdata"},      bus.ahbls_hrdata, 32'd0);
      check({tag, "_rd_en"},       {31'd0, bus.c_rd_en}, 32'd0);
      check({tag, "_wr_en"},       {31'd0, bus.c_wr_en}, 32'd0);
      check({tag, "_c_addr"},      bus.c_addr, 32'd0);
      check({tag, "_c_wdata"},     bus.c_wdata, 32'd0);
      check({tag, "_c_mask"},      {28'd0, bus.c_mask}, 32'd0);
      check({tag, "_perf_hit"},    bus.perf_rd_hit, 32'd0);
      check({tag, "_perf_miss"},   bus.perf_rd_miss, 32'd0);
   endtask

   // Cache/DRAM model: combinational hit data in the request cycle, otherwise busy for lat cycles.
   initial begin : cache_model
      req_t        r;
      bit          hit;
      bit          stable;
      bit          aborted;
      bit          is_wr;
      int          lat;
      int unsigned line;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] m_w;
      logic [3:0]  mk;
      bus.c_busy  = 1'b0;
      bus.c_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            cached.delete();
            bus.c_busy = 1'b0;
         end else if (bus.c_rd_en || bus.c_wr_en) begin
            pulses++;
            is_wr = bus.c_wr_en;
            a     = bus.c_addr;
            mk    = bus.c_mask;
            wd    = bus.c_wdata;
            check("req_expected", {31'd0, req_q.size() != 0}, 32'd1);
            if (req_q.size() != 0) begin
               r = req_q.pop_front();
               check("req_kind", {30'd0, bus.c_rd_en, bus.c_wr_en}, r.wr ? 32'd1 : 32'd2);
               check("req_addr", a, r.addr);
               check("req_mask", {28'd0, mk}, {28'd0, r.mask});
               if (r.wr) check("req_wdata", wd, r.wdata);
            end
            line = a >> 4;
            hit  = !is_wr && cached.exists(line);
            lat  = (force_lat != 0) ? force_lat : int'($urandom_range(1, 5));
            if (hit) begin
               bus.c_rdata = mem_word(a);
               exp_hit++;
            end else if (!is_wr) begin
               exp_miss++;
            end
            @(posedge clk); #1;
            if (!hit) begin
               bus.c_busy = 1'b1;
               stable     = 1'b1;
               aborted    = 1'b0;
               for (int i = 0; i < lat; i++) begin
                  @(negedge clk);
                  if (rst) begin
                     aborted = 1'b1;
                     break;
                  end
                  stable = stable && (bus.c_addr == a) && (bus.c_mask == mk) &&
                           (bus.c_wdata == wd) && !bus.c_rd_en && !bus.c_wr_en;
                  @(posedge clk); #1;
               end
               bus.c_busy = 1'b0;
               if (aborted) begin
                  cached.delete();
               end else begin
                  if (is_wr) begin
                     m_w = mem_word(a);
                     for (int b = 0; b < 4; b++) if (mk[b]) m_w[8*b +: 8] = wd[8*b +: 8];
                     mem[a] = m_w;
                  end
                  cached[line] = 1'b1;
                  bus.c_rdata  = mem_word(a);
                  check("hold_stable", {31'd0, stable}, 32'd1);
               end
            end
         end
      end
   end

   // Bus monitor: tracks data phases and pops one expected response per completion.
   initial begin : monitor
      bit    in_dp;
      bit    prev_err;
      resp_t e;
      in_dp    = 1'b0;
      prev_err = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_dp    = 1'b0;
            prev_err = 1'b0;
         end else begin
            if (in_dp && bus.ahbls_hready_resp) begin
               check("resp_expected", {31'd0, resp_q.size() != 0}, 32'd1);
               if (resp_q.size() != 0) begin
                  e = resp_q.pop_front();
                  check("hresp", {31'd0, bus.ahbls_hresp}, {31'd0, e.err});
                  if (e.err)      check("err_first_cycle", {31'd0, prev_err}, 32'd1);
                  else if (!e.wr) check("hrdata", bus.ahbls_hrdata, e.rdata);
               end
               last_cpl_cyc = cyc;
            end
            prev_err = in_dp && !bus.ahbls_hready_resp && bus.ahbls_hresp;
            if (bus.ahbls_hsel && bus.ahbls_hready && bus.ahbls_htrans[1]) in_dp = 1'b1;
            else if (bus.ahbls_hready_resp)                                in_dp = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int          n;
      int          p0;
      bit          wr;
      logic [2:0]  size;
      logic [31:0] a;
      rst              = 1'b1;
      bus.ahbls_hsel   = 1'b0;
      bus.ahbls_htrans = 2'b00;
      bus.ahbls_haddr  = '0;
      bus.ahbls_hwrite = 1'b0;
      bus.ahbls_hsize  = 3'd0;
      bus.ahbls_hwdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      idle(2);

      // Word read at 0x100: miss, then hit returning at A+2.
      issue(1'b0, 32'h100, 3'd2, $urandom);
      wait_drain();
      issue(1'b0, 32'h100, 3'd2, $urandom);
      count_to_ready(n);
      check("hit_latency", n, 32'd2);
      idle(1);
      wait_drain();
      check("perf_hit_first", bus.perf_rd_hit, 32'd1);
      check("perf_miss_first", bus.perf_rd_miss, 32'd1);

      // Byte write 0xAB at 0x203, then word read of 0x200.
      issue(1'b1, 32'h203, 3'd0, 32'hAB00_0000);
      issue(1'b0, 32'h200, 3'd2, $urandom);
      wait_drain();
      idle(1);

      // Misaligned half write: ERROR response and no cache request, then a normal read.
      p0 = pulses;
      issue(1'b1, 32'h301, 3'd1, $urandom);
      wait_drain();
      idle(1);
      check("err_no_pulse", pulses - p0, 32'd0);
      issue(1'b0, 32'h300, 3'd2, $urandom);
      wait_drain();

      // Back-to-back: read accepted in the write's completion cycle.
      issue(1'b1, 32'h400, 3'd2, $urandom);
      issue(1'b0, 32'h400, 3'd2, $urandom);
      @(negedge clk);
      check("b2b_rd_en", {31'd0, bus.c_rd_en}, 32'd1);
      check("b2b_gap", cyc - last_cpl_cyc, 32'd1);
      wait_drain();
      idle(1);

      // Long miss: busy for 40 cycles, one enable pulse.
      force_lat = 40;
      p0 = pulses;
      issue(1'b0, 32'h500, 3'd2, $urandom);
      count_to_ready(n);
      check("long_miss_latency", n, 32'd42);
      force_lat = 0;
      idle(1);
      wait_drain();
      check("long_miss_pulses", pulses - p0, 32'd1);

      // Reset asserted while waiting on the cache.
      force_lat = 20;
      issue(1'b0, 32'h600, 3'd2, $urandom);
      repeat (5) @(negedge clk);
      check("pre_reset_wait", {31'd0, bus.ahbls_hready_resp}, 32'd0);
      #2 rst = 1'b1;
      #1 check_reset_outputs("async_reset");
      resp_q.delete();
      exp_hit   = 0;
      exp_miss  = 0;
      force_lat = 0;
      bus.ahbls_hsel = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle(1);
      issue(1'b0, 32'h100, 3'd2, $urandom);
      wait_drain();

      // Randomised traffic over a small window so lines get reused.
      for (int t = 0; t < 250; t++) begin
         wr   = 1'($urandom_range(0, 1));
         size = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
         a    = 32'h1000 + $urandom_range(0, 255);
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << size) - 32'd1);
         issue(wr, a, size, $urandom);
         if ($urandom_range(0, 1) != 0) idle(int'($urandom_range(1, 3)));
      end
      wait_drain();
      idle(2);
      check("perf_rd_hit", bus.perf_rd_hit, exp_hit);
      check("perf_rd_miss", bus.perf_rd_miss, exp_miss);
      check("enable_pulses", pulses, exp_pulses);
      check("req_queue_empty", req_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
